// File: rtl/radix4_booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, signed/unsigned per operation.
// Define MULT_EARLY_TERM_EN to finish as soon as every remaining multiplier digit is zero.
module radix4_booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int N  = WIDTH/2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int UW = WIDTH + 3;
  localparam int AW = 2*WIDTH + 5;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [EW-1:0] a_q, a_d;
  logic signed [EW-1:0] b_q, b_d;
  logic                 bprev_q, bprev_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [2:0]           digit;
  logic                 neg;
  logic signed [UW-1:0] mag;
  logic signed [UW-1:0] upper_sum;

`ifdef MULT_EARLY_TERM_EN
  logic [EW:0]          rem;
  logic                 rem_same;
  logic [CW:0]          et_shamt;

  // Remaining bits are replicated by the arithmetic shift of b_q, so all-equal means all digits are 0.
  always_comb begin
    rem      = {b_q, bprev_q};
    rem_same = (&rem) | ~(|rem);
    et_shamt = {LAST - cnt_q, 1'b0};
  end
`endif

  // Booth digit decode and add into the upper accumulator slice; negation is invert plus carry-in.
  always_comb begin
    digit = {b_q[1:0], bprev_q};
    neg   = digit[2] & ~(digit[1] & digit[0]);
    unique case (digit)
      3'b001, 3'b010, 3'b101, 3'b110: mag = {a_q[EW-1], a_q};
      3'b011, 3'b100:                 mag = {a_q, 1'b0};
      default:                        mag = '0;
    endcase
    upper_sum = acc_q[AW-1:AW-UW] + (neg ? ~mag : mag) + UW'(neg);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    bprev_d   = bprev_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = signed_op ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
          b_d     = signed_op ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
          bprev_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          product_d = acc_q[2*WIDTH-1:0];
          state_d   = DONE;
        end
`ifdef MULT_EARLY_TERM_EN
        else if (rem_same) begin
          acc_d = acc_q >>> et_shamt;
          cnt_d = LAST;
        end
`endif
        else begin
          acc_d   = $signed({upper_sum, acc_q[AW-UW-1:0]}) >>> 2;
          b_d     = b_q >>> 2;
          bprev_d = b_q[1];
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      bprev_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      bprev_q   <= bprev_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_radix4_booth_seq_multiplier.sv
// Self-checking bench: WIDTH=8 directed vectors and corner sequences, WIDTH=32 latency and random ops.
module tb_radix4_booth_seq_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv32, ir32, s32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  radix4_booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .signed_op(s8),
    .multiplicand(a8), .multiplier(b8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8));

  radix4_booth_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .signed_op(s32),
    .multiplicand(a32), .multiplier(b32), .out_valid(ov32), .out_ready(or32),
    .product(p32), .busy(busy32));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec8_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec32_t;

  // Waits (bounded) for out_valid on the 8-bit instance; counts edges after the accept edge.
  task automatic wait8(output int lat, output int bad);
    lat = 0;
    bad = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      if (ir8 !== 1'b0 || busy8 !== 1'b1) bad++;
      @(posedge clk);
      #1 lat++;
    end
    if (ov8 !== 1'b1) check("wait8_timeout", {63'd0, ov8}, 64'd1);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat, output int bad);
    @(negedge clk);
    iv8 = 1'b1; s8 = s; a8 = a; b8 = b; or8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    wait8(lat, bad);
    p = p8;
    @(posedge clk);
    #1;
  endtask

  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                      output logic [63:0] p, output int lat);
    @(negedge clk);
    iv32 = 1'b1; s32 = s; a32 = a; b32 = b; or32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D;
    lat = 0;
    while (ov32 !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    if (ov32 !== 1'b1) check("wait32_timeout", {63'd0, ov32}, 64'd1);
    p = p32;
    @(posedge clk);
    #1;
  endtask

  vec8_t       tbl8[7];
  vec32_t      tbl32[4];
  logic [15:0] pr8;
  logic [63:0] pr32, exp64;
  logic [31:0] ra, rb;
  logic        rs, hs, done;
  int          lat, bad, got, dup, cyc;

  initial begin
    tbl8[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl8[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl8[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    tbl8[3] = '{1'b1, 8'h03, 8'hFB, 16'hFFF1};
    tbl8[4] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
    tbl8[5] = '{1'b0, 8'h00, 8'h00, 16'h0000};
    tbl8[6] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
`ifdef MULT_EARLY_TERM_EN
    tbl32[0] = '{1'b0, 32'h12345678, 32'h00000000, 64'h0000000000000000, 2};
    tbl32[1] = '{1'b0, 32'h12345678, 32'h00000001, 64'h0000000012345678, 3};
    tbl32[2] = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFFEDCBA988, 3};
    tbl32[3] = '{1'b0, 32'h12345678, 32'h80000000, 64'h091A2B3C00000000, 18};
`else
    tbl32[0] = '{1'b0, 32'h12345678, 32'h00000000, 64'h0000000000000000, 18};
    tbl32[1] = '{1'b0, 32'h12345678, 32'h00000001, 64'h0000000012345678, 18};
    tbl32[2] = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFFEDCBA988, 18};
    tbl32[3] = '{1'b0, 32'h12345678, 32'h80000000, 64'h091A2B3C00000000, 18};
`endif

    iv8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 0;
    iv32 = 0; s32 = 0; a32 = 0; b32 = 0; or32 = 0;
    rst = 1'b1;
    #1;
    check("rst_in_ready8", {63'd0, ir8}, 64'd1);
    check("rst_out_valid8", {63'd0, ov8}, 64'd0);
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_product8", {48'd0, p8}, 64'd0);
    check("rst_in_ready32", {63'd0, ir32}, 64'd1);
    check("rst_out_valid32", {63'd0, ov32}, 64'd0);
    check("rst_busy32", {63'd0, busy32}, 64'd0);
    check("rst_product32", p32, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed WIDTH=8 table
    for (int i = 0; i < 7; i++) begin
      op8(tbl8[i].s, tbl8[i].a, tbl8[i].b, pr8, lat, bad);
      check($sformatf("tbl8[%0d]_product", i), {48'd0, pr8}, {48'd0, tbl8[i].exp});
      check($sformatf("tbl8[%0d]_ready_low", i), 64'(bad), 64'd0);
`ifndef MULT_EARLY_TERM_EN
      check($sformatf("tbl8[%0d]_latency", i), 64'(lat), 64'd6);
`endif
      check($sformatf("tbl8[%0d]_ov_drop", i), {63'd0, ov8}, 64'd0);
      check($sformatf("tbl8[%0d]_ir_rise", i), {63'd0, ir8}, 64'd1);
    end

    // Backpressure: result held while new operands are offered and ignored
    @(negedge clk);
    iv8 = 1'b1; s8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; or8 = 1'b0;
    @(posedge clk);
    #1 iv8 = 1'b0;
    wait8(lat, bad);
    iv8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (p8 !== 16'hFE01 || ir8 !== 1'b0 || ov8 !== 1'b1) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    @(negedge clk) or8 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", {63'd0, ov8}, 64'd0);
    check("bp_release_ir", {63'd0, ir8}, 64'd1);
    @(posedge clk);
    #1;
    check("bp_new_accept", {63'd0, ir8}, 64'd0);
    iv8 = 1'b0;
    wait8(lat, bad);
    check("bp_new_product", {48'd0, p8}, 64'h000F);
`ifndef MULT_EARLY_TERM_EN
    check("bp_new_latency", 64'(lat), 64'd6);
`endif
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    iv8 = 1'b1; s8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; or8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, ov8}, 64'd0);
    check("midrst_in_ready", {63'd0, ir8}, 64'd1);
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_product", {48'd0, p8}, 64'd0);
    @(negedge clk) rst = 1'b0;
    op8(1'b0, 8'd7, 8'd6, pr8, lat, bad);
    check("postrst_product", {48'd0, pr8}, 64'h002A);
`ifndef MULT_EARLY_TERM_EN
    check("postrst_latency", 64'(lat), 64'd6);
`endif

    // WIDTH=32 latency and products
    for (int i = 0; i < 4; i++) begin
      op32(tbl32[i].s, tbl32[i].a, tbl32[i].b, pr32, lat);
      check($sformatf("tbl32[%0d]_product", i), pr32, tbl32[i].exp);
      check($sformatf("tbl32[%0d]_latency", i), 64'(lat), 64'(tbl32[i].lat));
    end

    // WIDTH=32 random ops with out_ready stalls
    got = 0;
    dup = 0;
    or32 = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (k % 7 == 0) ra = 32'h80000000;
      if (k % 11 == 0) rb = 32'hFFFFFFFF;
      if (k % 13 == 0) rb = 32'h00000000;
      exp64 = rs ? 64'(longint'($signed(ra)) * longint'($signed(rb)))
                 : ({32'd0, ra} * {32'd0, rb});
      @(negedge clk);
      if (ir32 !== 1'b1) dup++;
      iv32 = 1'b1; s32 = rs; a32 = ra; b32 = rb;
      @(posedge clk);
      #1 iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        or32 = ($urandom_range(0, 3) != 0);
        hs = ov32 && or32;
        if (hs) check($sformatf("rand[%0d]_product", k), p32, exp64);
        @(posedge clk);
        if (hs) begin
          done = 1'b1;
          got++;
        end
      end
      if (!done) check($sformatf("rand[%0d]_timeout", k), 64'd0, 64'd1);
      #1 if (ov32 !== 1'b0) dup++;
    end
    check("rand_result_count", 64'(got), 64'd2000);
    check("rand_no_dup", 64'(dup), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
